// File: rtl/sram_rmw_arbiter_if.sv
// Request/response and SRAM-side signal bundle for sram_rmw_arbiter.
// slave is the arbiter's view; master is the view of whatever drives requests and models the RAM.
interface sram_rmw_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int BE_W    = DATA_W / 8
);
    logic [NUM_REQ-1:0]        req_vld_i;
    logic [NUM_REQ-1:0]        req_rdy_o;
    logic [NUM_REQ-1:0]        req_we_i;
    logic [NUM_REQ*BE_W-1:0]   req_be_i;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
    logic [NUM_REQ*DATA_W-1:0] req_wdat_i;
    logic [NUM_REQ-1:0]        rsp_vld_o;
    logic                      rsp_we_o;
    logic [DATA_W-1:0]         rsp_rdat_o;
    logic                      ram_csel_o;
    logic                      ram_wren_o;
    logic [ADDR_W-1:0]         ram_addr_o;
    logic [DATA_W-1:0]         ram_wdat_o;
    logic [BE_W-1:0]           ram_ben_o;
    logic [DATA_W-1:0]         ram_rdat_i;

    modport slave (
        input  req_vld_i, req_we_i, req_be_i, req_addr_i, req_wdat_i, ram_rdat_i,
        output req_rdy_o, rsp_vld_o, rsp_we_o, rsp_rdat_o,
               ram_csel_o, ram_wren_o, ram_addr_o, ram_wdat_o, ram_ben_o
    );

    modport master (
        output req_vld_i, req_we_i, req_be_i, req_addr_i, req_wdat_i, ram_rdat_i,
        input  req_rdy_o, rsp_vld_o, rsp_we_o, rsp_rdat_o,
               ram_csel_o, ram_wren_o, ram_addr_o, ram_wdat_o, ram_ben_o
    );
endinterface

// File: rtl/sram_rmw_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// Byte-enabled writes are emulated with a read-modify-write because the macro ignores byte enables.
module sram_rmw_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 64,
    parameter int BE_W    = DATA_W / 8
) (
    input  logic                Clk_CI,
    input  logic                Rst_RBI,
    sram_rmw_arbiter_if.slave   bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, RD_RSP, RMW_WR, WR_RSP} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;

    logic              gnt_vld;
    logic [PTR_W-1:0]  gnt_idx;
    logic              sel_we;
    logic [BE_W-1:0]   sel_be;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdat;
    logic [DATA_W-1:0] merged;

    logic [NUM_REQ-1:0] req_rdy;
    logic [NUM_REQ-1:0] rsp_vld;
    logic               rsp_we;
    logic [DATA_W-1:0]  rsp_rdat;
    logic               ram_csel;
    logic               ram_wren;
    logic [ADDR_W-1:0]  ram_addr;
    logic [DATA_W-1:0]  ram_wdat;

    // Search from rr_ptr upward, then wrap to the low indices; nothing is granted during the merge write or reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (Rst_RBI && (state_q != RMW_WR)) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_vld && bus.req_vld_i[i] && (i >= int'(rr_ptr_q))) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(i);
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!gnt_vld && bus.req_vld_i[i]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = PTR_W'(i);
                end
            end
        end
    end

    always_comb begin
        sel_we   = 1'b0;
        sel_be   = '0;
        sel_addr = '0;
        sel_wdat = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
                sel_we   = bus.req_we_i[i];
                sel_be   = bus.req_be_i[i*BE_W +: BE_W];
                sel_addr = bus.req_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdat = bus.req_wdat_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        merged = '0;
        for (int b = 0; b < BE_W; b++) begin
            merged[b*8 +: 8] = be_q[b] ? wdat_q[b*8 +: 8] : bus.ram_rdat_i[b*8 +: 8];
        end
    end

    // Response of the previous operation and issue of the next one can share a cycle.
    always_comb begin
        state_d  = IDLE;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdat_d   = wdat_q;
        req_rdy  = '0;
        rsp_vld  = '0;
        rsp_we   = 1'b0;
        rsp_rdat = '0;
        ram_csel = 1'b0;
        ram_wren = 1'b0;
        ram_addr = '0;
        ram_wdat = '0;

        case (state_q)
            RD_RSP: begin
                rsp_vld  = NUM_REQ'(1) << id_q;
                rsp_rdat = bus.ram_rdat_i;
            end
            WR_RSP: begin
                rsp_vld = NUM_REQ'(1) << id_q;
                rsp_we  = 1'b1;
            end
            RMW_WR: begin
                ram_csel = 1'b1;
                ram_wren = 1'b1;
                ram_addr = addr_q;
                ram_wdat = merged;
                state_d  = WR_RSP;
            end
            default: ;
        endcase

        if (gnt_vld) begin
            req_rdy = NUM_REQ'(1) << gnt_idx;
            id_d    = gnt_idx;
            if (int'(gnt_idx) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = gnt_idx + 1'b1;
            end
            if (!sel_we) begin
                ram_csel = 1'b1;
                ram_addr = sel_addr;
                state_d  = RD_RSP;
            end else if (&sel_be) begin
                ram_csel = 1'b1;
                ram_wren = 1'b1;
                ram_addr = sel_addr;
                ram_wdat = sel_wdat;
                state_d  = WR_RSP;
            end else if (|sel_be) begin
                ram_csel = 1'b1;
                ram_addr = sel_addr;
                addr_d   = sel_addr;
                be_d     = sel_be;
                wdat_d   = sel_wdat;
                state_d  = RMW_WR;
            end else begin
                state_d  = WR_RSP;
            end
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            be_q     <= '0;
            wdat_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdat_q   <= wdat_d;
        end
    end

    assign bus.req_rdy_o  = req_rdy;
    assign bus.rsp_vld_o  = rsp_vld;
    assign bus.rsp_we_o   = rsp_we;
    assign bus.rsp_rdat_o = rsp_rdat;
    assign bus.ram_csel_o = ram_csel;
    assign bus.ram_wren_o = ram_wren;
    assign bus.ram_addr_o = ram_addr;
    assign bus.ram_wdat_o = ram_wdat;
    assign bus.ram_ben_o  = {BE_W{1'b1}};
endmodule

// File: tb/tb_sram_rmw_arbiter.sv
// Scoreboard bench for sram_rmw_arbiter: a memory-level reference model predicts grants and
// responses at issue time, and an independent monitor checks every response cycle.
module tb_sram_rmw_arbiter;
    localparam int NUM_REQ = 2;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 64;
    localparam int BE_W    = 8;

    typedef struct {
        int          id;
        logic        we;
        logic [63:0] rdat;
        longint      due;
    } rsp_t;

    logic clk   = 1'b0;
    logic rstN  = 1'b0;
    logic memInit = 1'b1;
    longint cyc = 0;

    int compared   = 0;
    int mismatched = 0;

    rsp_t sbq[$];
    logic monOn = 1'b0;

    logic [63:0] refMem [256];
    logic [63:0] sramMem [256];

    logic       vldA  [NUM_REQ];
    logic       weA   [NUM_REQ];
    logic [7:0] beA   [NUM_REQ];
    logic [7:0] addrA [NUM_REQ];
    logic [63:0] wdatA [NUM_REQ];

    int          ptr = 0;
    bit          blocked = 0;
    logic [7:0]  pendAddr;
    logic [63:0] pendData;
    int          lastGrant = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    sram_rmw_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) bus ();

    sram_rmw_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
        .Clk_CI  (clk),
        .Rst_RBI (rstN),
        .bus     (bus)
    );

    // Behavioural single-port SRAM: read data appears the cycle after a read strobe.
    always @(posedge clk) begin
        if (memInit) begin
            for (int i = 0; i < 256; i++) sramMem[i] <= (i == 32) ? 64'h5A : 64'h0;
        end else if (bus.ram_csel_o) begin
            if (bus.ram_wren_o) sramMem[bus.ram_addr_o] <= bus.ram_wdat_o;
            else bus.ram_rdat_i <= sramMem[bus.ram_addr_o];
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: each cycle the DUT must present exactly the response due now, or none.
    rsp_t monEnt;
    logic [NUM_REQ-1:0] monExpVld;
    always @(negedge clk) begin
        if (monOn) begin
            monExpVld = '0;
            monEnt.id = 0;
            monEnt.we = 1'b0;
            monEnt.rdat = '0;
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                monEnt = sbq.pop_front();
                monExpVld[monEnt.id] = 1'b1;
            end
            checkOutput("rsp_vld", bus.rsp_vld_o, monExpVld);
            if (monExpVld != '0) begin
                checkOutput("rsp_we", bus.rsp_we_o, monEnt.we);
                checkOutput("rsp_rdat", bus.rsp_rdat_o, monEnt.rdat);
            end
        end
    end

    task automatic applyStimulus();
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_vld_i[r] = vldA[r];
            bus.req_we_i[r]  = weA[r];
            bus.req_be_i[r*BE_W +: BE_W]       = beA[r];
            bus.req_addr_i[r*ADDR_W +: ADDR_W] = addrA[r];
            bus.req_wdat_i[r*DATA_W +: DATA_W] = wdatA[r];
        end
    endtask

    task automatic clearReq();
        for (int r = 0; r < NUM_REQ; r++) begin
            vldA[r] = 1'b0; weA[r] = 1'b0; beA[r] = '0; addrA[r] = '0; wdatA[r] = '0;
        end
    endtask

    // Reference model: decides the grant, checks the RAM pins and predicts the response.
    task automatic evaluateCycle();
        int g;
        logic [NUM_REQ-1:0] expRdy;
        logic [63:0] mask;
        logic [63:0] newW;
        logic [7:0] a;
        bit blockNext;
        rsp_t ent;
        g = -1;
        expRdy = '0;
        blockNext = 0;
        if (!blocked) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                int idx = (ptr + k) % NUM_REQ;
                if (g < 0 && vldA[idx]) g = idx;
            end
        end
        if (g >= 0) expRdy[g] = 1'b1;
        lastGrant = g;
        checkOutput("req_rdy", bus.req_rdy_o, expRdy);
        checkOutput("ram_ben", bus.ram_ben_o, 8'hFF);
        if (blocked) begin
            checkOutput("rmw_csel", bus.ram_csel_o, 1);
            checkOutput("rmw_wren", bus.ram_wren_o, 1);
            checkOutput("rmw_addr", bus.ram_addr_o, pendAddr);
            checkOutput("rmw_wdat", bus.ram_wdat_o, pendData);
        end else if (g < 0) begin
            checkOutput("idle_csel", bus.ram_csel_o, 0);
            checkOutput("idle_wren", bus.ram_wren_o, 0);
        end else begin
            a = addrA[g];
            ent.id = g;
            ent.due = cyc + 1;
            ent.we = 1'b1;
            ent.rdat = '0;
            if (!weA[g]) begin
                checkOutput("rd_csel", bus.ram_csel_o, 1);
                checkOutput("rd_wren", bus.ram_wren_o, 0);
                checkOutput("rd_addr", bus.ram_addr_o, a);
                ent.we = 1'b0;
                ent.rdat = refMem[a];
            end else if (beA[g] == 8'hFF) begin
                checkOutput("wr_csel", bus.ram_csel_o, 1);
                checkOutput("wr_wren", bus.ram_wren_o, 1);
                checkOutput("wr_addr", bus.ram_addr_o, a);
                checkOutput("wr_wdat", bus.ram_wdat_o, wdatA[g]);
                refMem[a] = wdatA[g];
            end else if (beA[g] == 8'h00) begin
                checkOutput("zbe_csel", bus.ram_csel_o, 0);
                checkOutput("zbe_wren", bus.ram_wren_o, 0);
            end else begin
                checkOutput("prd_csel", bus.ram_csel_o, 1);
                checkOutput("prd_wren", bus.ram_wren_o, 0);
                checkOutput("prd_addr", bus.ram_addr_o, a);
                for (int b = 0; b < 8; b++) mask[b*8 +: 8] = {8{beA[g][b]}};
                newW = (wdatA[g] & mask) | (refMem[a] & ~mask);
                refMem[a] = newW;
                pendAddr = a;
                pendData = newW;
                ent.due = cyc + 2;
                blockNext = 1;
            end
            sbq.push_back(ent);
            ptr = (g + 1) % NUM_REQ;
        end
        blocked = blockNext;
    endtask

    task automatic step();
        applyStimulus();
        @(negedge clk);
        evaluateCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int r, input logic we, input logic [7:0] be,
                         input logic [7:0] addr, input logic [63:0] wdat);
        int tries = 0;
        clearReq();
        vldA[r] = 1'b1; weA[r] = we; beA[r] = be; addrA[r] = addr; wdatA[r] = wdat;
        lastGrant = -1;
        while (lastGrant != r && tries < 4) begin
            step();
            tries++;
        end
        if (lastGrant != r) checkOutput("issue_grant", lastGrant, r);
        clearReq();
    endtask

    logic [63:0] savedOld;

    initial begin
        for (int i = 0; i < 256; i++) refMem[i] = (i == 32) ? 64'h5A : 64'h0;
        clearReq();
        for (int r = 0; r < NUM_REQ; r++) begin vldA[r] = 1'b1; addrA[r] = 8'h10; end
        applyStimulus();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1 memInit = 1'b0;
        @(negedge clk);
        checkOutput("reset_rdy", bus.req_rdy_o, 0);
        checkOutput("reset_rsp_vld", bus.rsp_vld_o, 0);
        checkOutput("reset_rsp_we", bus.rsp_we_o, 0);
        checkOutput("reset_rsp_rdat", bus.rsp_rdat_o, 0);
        checkOutput("reset_csel", bus.ram_csel_o, 0);
        checkOutput("reset_wren", bus.ram_wren_o, 0);
        checkOutput("reset_ben", bus.ram_ben_o, 8'hFF);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        monOn = 1'b1;
        clearReq();

        $display("[TB] full write then read");
        issue(0, 1'b1, 8'hFF, 8'h10, 64'h0123_4567_89AB_CDEF);
        issue(0, 1'b0, 8'h00, 8'h10, 64'h0);
        $display("[TB] partial write then read");
        issue(0, 1'b1, 8'h0F, 8'h10, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(0, 1'b0, 8'h00, 8'h10, 64'h0);
        step();
        $display("[TB] round-robin contention");
        clearReq();
        for (int r = 0; r < NUM_REQ; r++) begin vldA[r] = 1'b1; addrA[r] = 8'h00; end
        repeat (6) step();
        clearReq();
        $display("[TB] zero byte-enable write");
        issue(1, 1'b1, 8'h00, 8'h20, 64'hDEAD_BEEF_DEAD_BEEF);
        issue(1, 1'b0, 8'h00, 8'h20, 64'h0);
        $display("[TB] read blocked behind RMW");
        issue(1, 1'b1, 8'hF0, 8'h40, 64'h1111_2222_3333_4444);
        issue(0, 1'b0, 8'h00, 8'h40, 64'h0);
        step();

        $display("[TB] random traffic");
        for (int c = 0; c < 600; c++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                int sel = $urandom_range(0, 3);
                vldA[r]  = ($urandom_range(0, 9) < 6);
                weA[r]   = 1'($urandom_range(0, 1));
                beA[r]   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
                addrA[r] = 8'($urandom_range(0, 7));
                wdatA[r] = {$urandom, $urandom};
            end
            step();
        end

        $display("[TB] reset during RMW");
        clearReq();
        step();
        step();
        savedOld = refMem[8'h30];
        vldA[0] = 1'b1; weA[0] = 1'b1; beA[0] = 8'h3C; addrA[0] = 8'h30; wdatA[0] = ~savedOld;
        step();
        clearReq();
        applyStimulus();
        checkOutput("rmw_active_wren", bus.ram_wren_o, 1);
        rstN = 1'b0;
        #1;
        checkOutput("rst_rmw_wren", bus.ram_wren_o, 0);
        checkOutput("rst_rmw_csel", bus.ram_csel_o, 0);
        checkOutput("rst_rmw_rsp_vld", bus.rsp_vld_o, 0);
        if (sbq.size() > 0) void'(sbq.pop_back());
        refMem[8'h30] = savedOld;
        ptr = 0;
        blocked = 0;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin vldA[r] = 1'b1; addrA[r] = 8'h30; end
        step();
        clearReq();
        step();

        for (int i = 0; i < 6 && sbq.size() > 0; i++) step();
        if (sbq.size() != 0) checkOutput("drain", sbq.size(), 0);
        @(negedge clk);
        monOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
